// File: rtl/nibble_unpacker_pkg.sv
// Shared types for the byte-to-nibble unpacker: byte/nibble widths and the FSM state enum.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [7:0]          byte_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/nibble_unpacker_if.sv
// Byte-in / nibble-out valid-ready bundle for nibble_unpacker; slave is the unpacker's view.
interface nibble_unpacker_if;
  import nibble_pkg::*;

  logic       in_valid;
  logic       in_ready;
  byte_t      in_data;
  logic       out_valid;
  logic       out_ready;
  nibble_t    out_data;
  logic       out_last;
  logic [7:0] byte_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, byte_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, byte_cnt
  );

endinterface

// File: rtl/nibble_unpacker_sel.sv
// nibble_sel: picks the nibble of a byte for the given phase (0 = first, 1 = second) and order.
module nibble_sel
  import nibble_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0
) (
  input  byte_t   data,
  input  logic    phase,
  output nibble_t nib
);

  typedef logic [0:0] half_idx_t;

  half_idx_t half;

  always_comb begin
    half = half_idx_t'(phase ^ HI_FIRST);
    nib  = nibble_t'(data >> (NIBBLE_W * int'(half)));
  end

endmodule

// File: rtl/nibble_unpacker.sv
// Byte-to-nibble width converter. Define NIBBLE_UNPACKER_ASSERT_EN to build in protocol assertions.
module nibble_unpacker
  import nibble_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  nibble_unpacker_if.slave   bus
);

  unpack_state_t state_q;
  byte_t         hold_q;
  logic [7:0]    cnt_q;
  nibble_t       sel_nib;
  logic          in_ready;
  logic          in_hs;

  // A new byte may enter while the last nibble of the current one leaves.
  assign in_ready = rst_n && ((state_q == ST_EMPTY) ||
                              ((state_q == ST_SECOND) && bus.out_ready));
  assign in_hs    = bus.in_valid && in_ready;

  nibble_sel #(.HI_FIRST(HI_FIRST)) u_sel (
    .data  (hold_q),
    .phase (state_q == ST_SECOND),
    .nib   (sel_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      if (in_hs) begin
        hold_q <= bus.in_data;
        cnt_q  <= cnt_q + 8'd1;
      end
      case (state_q)
        ST_EMPTY:  if (in_hs) state_q <= ST_FIRST;
        ST_FIRST:  if (bus.out_ready) state_q <= ST_SECOND;
        ST_SECOND: if (bus.out_ready) state_q <= in_hs ? ST_FIRST : ST_EMPTY;
        default:   state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_last  = (state_q == ST_SECOND);
  assign bus.out_data  = (state_q == ST_EMPTY) ? nibble_t'(4'h0) : sel_nib;
  assign bus.byte_cnt  = cnt_q;

`ifdef NIBBLE_UNPACKER_ASSERT_EN
  nibble_t prev_data;
  logic    prev_last;
  logic    prev_stall;
  nibble_t exp_nib;

  always @(*) begin
    exp_nib = ((state_q == ST_SECOND) ^ HI_FIRST) ? nibble_t'(hold_q[7:4])
                                                   : nibble_t'(hold_q[3:0]);
    assert (state_q != unpack_state_t'(2'd3));
    assert (!bus.out_valid || (state_q != ST_EMPTY));
  end

  always @(posedge clk) begin
    if (rst_n && prev_stall)
      assert ((bus.out_data == prev_data) && (bus.out_last == prev_last));
    if (rst_n && bus.out_valid && bus.out_ready)
      assert (bus.out_data == exp_nib);
    prev_stall <= rst_n && bus.out_valid && !bus.out_ready;
    prev_data  <= bus.out_data;
    prev_last  <= bus.out_last;
  end
`endif

endmodule

// File: tb/tb_nibble_unpacker.sv
// Randomized and directed bench for nibble_unpacker, both nibble orders side by side.
module tb_nibble_unpacker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes not yet fully emitted, and which nibble of the front byte is pending.
  logic [7:0] bq[$];
  int         ph = 0;
  logic [7:0] mcnt = 8'h00;

  always #5 clk = ~clk;

  nibble_unpacker_if if0 ();
  nibble_unpacker_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;

  nibble_unpacker #(.HI_FIRST(1'b0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(if0));
  nibble_unpacker #(.HI_FIRST(1'b1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pick(input logic [7:0] b, input int half);
    return 4'((b >> (4 * half)) & 8'h0F);
  endfunction

  // Scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    int   pend;
    logic exp_v, exp_ir;
    if (rst_n) begin
      pend   = 2 * bq.size() - ph;
      exp_v  = (pend != 0);
      exp_ir = (pend == 0) || ((pend == 1) && out_ready);
      check("out_valid_lo", if0.out_valid, exp_v);
      check("out_valid_hi", if1.out_valid, exp_v);
      check("in_ready_lo", if0.in_ready, exp_ir);
      check("in_ready_hi", if1.in_ready, exp_ir);
      check("byte_cnt_lo", if0.byte_cnt, mcnt);
      check("byte_cnt_hi", if1.byte_cnt, mcnt);
      if (exp_v) begin
        check("out_data_lo", if0.out_data, pick(bq[0], ph));
        check("out_data_hi", if1.out_data, pick(bq[0], 1 - ph));
        check("out_last_lo", if0.out_last, (ph == 1));
        check("out_last_hi", if1.out_last, (ph == 1));
        if (out_ready) begin
          if (ph == 1) begin
            void'(bq.pop_front());
            ph = 0;
          end else begin
            ph = 1;
          end
        end
      end else begin
        check("idle_data_lo", if0.out_data, 4'h0);
        check("idle_data_hi", if1.out_data, 4'h0);
      end
      if (in_valid && exp_ir) begin
        bq.push_back(in_data);
        mcnt = mcnt + 8'd1;
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_now();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_valid_lo", if0.out_valid, 1'b0);
    check("rst_valid_hi", if1.out_valid, 1'b0);
    check("rst_data_lo", if0.out_data, 4'h0);
    check("rst_last_lo", if0.out_last, 1'b0);
    check("rst_cnt_lo", if0.byte_cnt, 8'h00);
    check("rst_ready_lo", if0.in_ready, 1'b0);
    bq.delete();
    ph   = 0;
    mcnt = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", if0.in_ready, 1'b1);
  endtask

  initial begin
    reset_now();

    // A5, LSB-first on dut_lo and MSB-first on dut_hi.
    cyc(1'b1, 8'hA5, 1'b1);
    check("a5_first_lo", if0.out_data, 4'h5);
    check("a5_first_hi", if1.out_data, 4'hA);
    check("a5_first_last", if0.out_last, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("a5_second_lo", if0.out_data, 4'hA);
    check("a5_second_hi", if1.out_data, 4'h5);
    check("a5_second_last", if1.out_last, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("a5_cnt", if0.byte_cnt, 8'd1);
    check("a5_idle", if0.out_valid, 1'b0);

    // Back-to-back bytes with no bubble.
    reset_now();
    cyc(1'b1, 8'h5A, 1'b1);
    check("b2b_n0", if0.out_data, 4'hA);
    cyc(1'b1, 8'h42, 1'b1);
    check("b2b_n1", if0.out_data, 4'h5);
    check("b2b_ready_second", if0.in_ready, 1'b1);
    cyc(1'b1, 8'h42, 1'b1);
    check("b2b_n2", if0.out_data, 4'h2);
    cyc(1'b0, 8'h00, 1'b1);
    check("b2b_n3", if0.out_data, 4'h4);
    cyc(1'b0, 8'h00, 1'b1);
    check("b2b_cnt", if0.byte_cnt, 8'd2);

    // Stall on the first nibble of 3C.
    cyc(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      check("stall_data", if0.out_data, 4'hC);
      check("stall_last", if0.out_last, 1'b0);
      check("stall_ready", if0.in_ready, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    check("stall_rel", if0.out_data, 4'h3);
    cyc(1'b0, 8'h00, 1'b1);

    // Counter wrap after 256 accepted bytes.
    reset_now();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("wrap_cnt0", if0.byte_cnt, 8'h00);
    cyc(1'b1, 8'h77, 1'b1);
    check("wrap_cnt1", if0.byte_cnt, 8'h01);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);

    // Asynchronous reset while holding 96.
    cyc(1'b1, 8'h96, 1'b0);
    check("pre_rst_valid", if0.out_valid, 1'b1);
    reset_now();
    repeat (4) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("no_96_after_rst", if0.out_valid, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(2) != 0));
    repeat (4) cyc(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
